pc_sequencer: RTL

Parametrised program-counter sequencer for the single-cycle CPU, replacing the fixed 32-bit PC/adder/branch-mux logic inside the core. It holds the PC register and computes the sequential and branch-target addresses. It resolves jump, beq and bne requests, freezes on instruction- or data-memory busy, and keeps saturating instruction and taken-branch counters. It sits between the control unit/ALU ZERO flag and the instruction memory address port.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/branch_target_adder.sv | 23 ++
 rtl/pc_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, reset vector, fetch step
// and the branch-control bundle that the control unit drives.
package cpu_pkg;

    // Sequencer states. HOLD is only ever seen for the one edge after reset.
    typedef enum logic [1:0] {
        StHold  = 2'b00,
        StRun   = 2'b01,
        StStall = 2'b10
    } pc_state_e;

    // Default sequential fetch step in bytes.
    localparam int unsigned DefaultInstrBytes = 4;

    // Default reset vector.
    localparam logic [31:0] ResetVec = 32'h0000_0000;

    // Branch-control bundle produced by the control unit.
    typedef struct packed {
        logic jump;
        logic beq;
        logic bne;
    } ctrl_bundle_t;

    // Taken decision. BEQ and BNE may be high together; the equation decides.
    function automatic logic branch_taken(input ctrl_bundle_t ctrl, input logic zero);
        return ctrl.jump | (ctrl.beq & zero) | (ctrl.bne & ~zero);
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch/jump target adder: sign-extends an offset, scales it by a left
// shift and adds it to a base address. Wraps modulo 2^ADDR_W.
module branch_target_adder #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned OFF_W     = 8,
    parameter int unsigned OFF_SHIFT = 2
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] off_scaled;

    // Sign-extend first so the shift keeps negative offsets negative.
    always_comb begin
        off_ext    = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
        off_scaled = off_ext << OFF_SHIFT;
        target     = base + off_scaled;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, resolves jump/beq/bne, freezes on
// memory busy and keeps saturating retired-instruction and taken-branch counts.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned      ADDR_W      = 32,
    parameter int unsigned      OFF_W       = 8,
    parameter int unsigned      OFF_SHIFT   = 2,
    parameter int unsigned      INSTR_BYTES = DefaultInstrBytes,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(ResetVec),
    parameter int unsigned      CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              JUMP,
    input  logic              BEQ,
    input  logic              BNE,
    input  logic              ZERO,
    input  logic [OFF_W-1:0]  OFFSET,
    input  logic              IMEM_BUSY,
    input  logic              DMEM_BUSY,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_NEXT_SEQ,
    output logic              PC_VALID,
    output logic              STALLED,
    output logic [CNT_W-1:0]  INSTR_CNT,
    output logic [CNT_W-1:0]  BR_CNT
);

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_valid_q;
    logic              stalled_q;
    logic [CNT_W-1:0]  instr_cnt_q;
    logic [CNT_W-1:0]  br_cnt_q;

    ctrl_bundle_t      ctrl;
    logic              busy;
    logic              taken;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_target;
    logic [ADDR_W-1:0] pc_next;

    // Target is relative to the sequential address, not to the current PC.
    branch_target_adder #(
        .ADDR_W    (ADDR_W),
        .OFF_W     (OFF_W),
        .OFF_SHIFT (OFF_SHIFT)
    ) u_target_adder (
        .base   (pc_seq),
        .offset (OFFSET),
        .target (pc_target)
    );

    // Sequential address, branch decision and next-PC select.
    always_comb begin
        ctrl.jump = JUMP;
        ctrl.beq  = BEQ;
        ctrl.bne  = BNE;
        busy      = IMEM_BUSY | DMEM_BUSY;
        pc_seq    = pc_q + ADDR_W'(INSTR_BYTES);
        taken     = branch_taken(ctrl, ZERO);
        pc_next   = taken ? pc_target : pc_seq;
    end

    // FSM, PC and saturating counters; reset is synchronous and wins over all.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= StHold;
            pc_q        <= RESET_VEC;
            pc_valid_q  <= 1'b0;
            stalled_q   <= 1'b0;
            instr_cnt_q <= '0;
            br_cnt_q    <= '0;
        end else begin
            // Every non-reset edge leaves HOLD, so the PC is fetchable after it.
            pc_valid_q <= 1'b1;
            unique case (state_q)
                StHold: begin
                    state_q   <= StRun;
                    stalled_q <= 1'b0;
                end
                StRun, StStall: begin
                    if (busy) begin
                        // Branch inputs are ignored; upstream holds them stable.
                        state_q   <= StStall;
                        stalled_q <= 1'b1;
                    end else begin
                        state_q   <= StRun;
                        stalled_q <= 1'b0;
                        pc_q      <= pc_next;
                        if (instr_cnt_q != '1) begin
                            instr_cnt_q <= instr_cnt_q + CNT_W'(1);
                        end
                        if (taken && (br_cnt_q != '1)) begin
                            br_cnt_q <= br_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= StHold;
                    stalled_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs straight from registers, except the combinational sequential PC.
    always_comb begin
        PC          = pc_q;
        PC_NEXT_SEQ = pc_seq;
        PC_VALID    = pc_valid_q;
        STALLED     = stalled_q;
        INSTR_CNT   = instr_cnt_q;
        BR_CNT      = br_cnt_q;
    end

endmodule
